// File: rtl/upsample_layer_sched.sv
// upsample_layer_sched: fires the upsample engine once per channel plane and rebases its addresses into flat memory
module upsample_layer_sched #(
    parameter int ADDR_W  = 14,
    parameter int CH_W    = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_size,
    input  logic [CH_W-1:0]   cmd_nch,
    input  logic [ADDR_W-1:0] cmd_in_base,
    input  logic [ADDR_W-1:0] cmd_out_base,
    output logic              up_start,
    output logic [2:0]        up_size,
    input  logic              up_done,
    input  logic [ADDR_W-1:0] up_addr_input,
    input  logic [ADDR_W-1:0] up_addr_output,
    output logic [ADDR_W-1:0] mem_addr_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [CH_W-1:0]   ch_idx,
    output logic              busy,
    output logic              layer_done,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_NEXT, S_DONE} state_t;
    localparam logic [31:0] TO = TIMEOUT;
    state_t            r_state;
    logic [ADDR_W-1:0] r_in_base, r_out_base, r_in_stride, r_out_stride;
    logic [CH_W-1:0]   r_nch, r_ch;
    logic [2:0]        r_size;
    logic              r_start, r_ld, r_err;
    logic [31:0]       r_wd;
    logic              w_timeout, w_last;
    // watchdog holds cycles elapsed since the up_start cycle
    assign w_timeout    = (TO != 32'd0) && (r_wd + 32'd1 >= TO);
    assign w_last       = r_ch == r_nch - CH_W'(1);
    assign cmd_ready    = r_state == S_IDLE;
    assign busy         = r_state != S_IDLE;
    assign up_start     = r_start;
    assign up_size      = r_size;
    assign ch_idx       = r_ch;
    assign layer_done   = r_ld;
    assign err          = r_err;
    assign mem_addr_in  = r_in_base + r_in_stride * ADDR_W'(r_ch) + up_addr_input;
    assign mem_addr_out = r_out_base + r_out_stride * ADDR_W'(r_ch) + up_addr_output;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_in_base    <= '0;
            r_out_base   <= '0;
            r_in_stride  <= '0;
            r_out_stride <= '0;
            r_nch        <= '0;
            r_ch         <= '0;
            r_size       <= '0;
            r_start      <= 1'b0;
            r_ld         <= 1'b0;
            r_err        <= 1'b0;
            r_wd         <= '0;
        end else begin
            r_start <= 1'b0;
            r_ld    <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: if (cmd_valid) begin
                    if (cmd_size[2]) r_err <= 1'b1;
                    else if (cmd_nch == '0) r_ld <= 1'b1;
                    else begin
                        r_in_base    <= cmd_in_base;
                        r_out_base   <= cmd_out_base;
                        r_in_stride  <= ADDR_W'(32'd16 << {cmd_size[1:0], 1'b0});
                        r_out_stride <= ADDR_W'(32'd64 << {cmd_size[1:0], 1'b0});
                        r_nch        <= cmd_nch;
                        r_size       <= cmd_size;
                        r_ch         <= '0;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_start <= 1'b1;
                    r_state <= S_START;
                end
                S_START: begin
                    r_wd    <= 32'd1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (up_done) r_state <= S_NEXT;
                    else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else r_wd <= r_wd + 32'd1;
                end
                S_NEXT: if (!up_done) begin
                    if (w_last) begin
                        r_ld    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ch    <= r_ch + CH_W'(1);
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_upsample_layer_sched.sv
// tb_upsample_layer_sched: directed vector bench for the upsample channel scheduler
module tb_upsample_layer_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_size = '0;
    logic [7:0]  cmd_nch = '0;
    logic [13:0] cmd_in_base = '0;
    logic [13:0] cmd_out_base = '0;
    logic        up_start;
    logic [2:0]  up_size;
    logic        up_done = 1'b0;
    logic [13:0] up_addr_input = '0;
    logic [13:0] up_addr_output = '0;
    logic [13:0] mem_addr_in, mem_addr_out;
    logic [7:0]  ch_idx;
    logic        busy, layer_done, err;
    int checks = 0, failures = 0;
    int n_start = 0, n_ld = 0, n_err = 0;

    upsample_layer_sched #(.ADDR_W(14), .CH_W(8), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_size(cmd_size), .cmd_nch(cmd_nch), .cmd_in_base(cmd_in_base),
        .cmd_out_base(cmd_out_base), .up_start(up_start), .up_size(up_size),
        .up_done(up_done), .up_addr_input(up_addr_input), .up_addr_output(up_addr_output),
        .mem_addr_in(mem_addr_in), .mem_addr_out(mem_addr_out), .ch_idx(ch_idx),
        .busy(busy), .layer_done(layer_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (up_start === 1'b1) n_start++;
        if (layer_done === 1'b1) n_ld++;
        if (err === 1'b1) n_err++;
    end

    typedef struct {
        logic [2:0]  size;
        logic [7:0]  ch;
        logic [13:0] in_base, out_base, ui, uo, exp_in, exp_out;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] s, input logic [7:0] n, input logic [13:0] ib, input logic [13:0] ob);
        cmd_size = s;
        cmd_nch = n;
        cmd_in_base = ib;
        cmd_out_base = ob;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
    endtask

    // from a START cycle: two WAIT cycles, one-cycle done pulse, then NEXT sees it low
    task automatic plane_pulse;
        tick;
        tick;
        up_done = 1'b1;
        tick;
        up_done = 1'b0;
        tick;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int s0, l0, e0;
        s0 = n_start;
        l0 = n_ld;
        e0 = n_err;
        send(v.size, v.ch + 8'd1, v.in_base, v.out_base);
        chk($sformatf("v%0d load_busy", idx), busy, 1);
        chk($sformatf("v%0d load_nostart", idx), up_start, 0);
        tick;
        for (int p = 0; p <= int'(v.ch); p++) begin
            chk($sformatf("v%0d p%0d start", idx, p), up_start, 1);
            chk($sformatf("v%0d p%0d ch_idx", idx, p), ch_idx, p);
            tick;
            if (p == int'(v.ch)) begin
                up_addr_input = v.ui;
                up_addr_output = v.uo;
                #1;
                chk($sformatf("v%0d mem_addr_in", idx), mem_addr_in, v.exp_in);
                chk($sformatf("v%0d mem_addr_out", idx), mem_addr_out, v.exp_out);
                chk($sformatf("v%0d up_size", idx), up_size, v.size);
            end
            tick;
            up_done = 1'b1;
            tick;
            up_done = 1'b0;
            tick;
        end
        chk($sformatf("v%0d layer_done", idx), layer_done, 1);
        tick;
        chk($sformatf("v%0d layer_done_pulse", idx), layer_done, 0);
        chk($sformatf("v%0d ready_after", idx), cmd_ready, 1);
        chk($sformatf("v%0d start_count", idx), n_start - s0, int'(v.ch) + 1);
        chk($sformatf("v%0d done_count", idx), n_ld - l0, 1);
        chk($sformatf("v%0d err_count", idx), n_err - e0, 0);
    endtask

    initial begin
        vec_t vecs[5];
        int s0, l0, e0;
        logic seen;
        vecs[0] = '{3'd1, 8'd2, 14'h0100, 14'h2000, 14'h0005, 14'h0007, 14'h0185, 14'h2207};
        vecs[1] = '{3'd3, 8'd0, 14'h0000, 14'h3F00, 14'h0000, 14'h0200, 14'h0000, 14'h0100};
        vecs[2] = '{3'd0, 8'd3, 14'h0010, 14'h0020, 14'h0001, 14'h0002, 14'h0041, 14'h00E2};
        vecs[3] = '{3'd2, 8'd1, 14'h1000, 14'h0000, 14'h0003, 14'h0010, 14'h1103, 14'h0410};
        vecs[4] = '{3'd3, 8'd4, 14'h3C00, 14'h0100, 14'h0005, 14'h0000, 14'h0C05, 14'h0100};

        repeat (2) tick;
        rst = 1'b0;
        tick;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst up_start", up_start, 0);
        chk("rst layer_done", layer_done, 0);
        chk("rst err", err, 0);
        chk("rst ch_idx", ch_idx, 0);
        chk("rst up_size", up_size, 0);

        s0 = n_start;
        l0 = n_ld;
        send(3'd5, 8'd2, 14'h0, 14'h0);
        chk("illegal err", err, 1);
        chk("illegal ready", cmd_ready, 1);
        chk("illegal busy", busy, 0);
        tick;
        chk("illegal err_pulse", err, 0);
        send(3'd0, 8'd0, 14'h0, 14'h0);
        chk("nch0 layer_done", layer_done, 1);
        chk("nch0 ready", cmd_ready, 1);
        tick;
        chk("nch0 layer_done_pulse", layer_done, 0);
        repeat (3) tick;
        chk("nocmd start_count", n_start - s0, 0);
        chk("nocmd done_count", n_ld - l0, 1);

        l0 = n_ld;
        send(3'd0, 8'd2, 14'h0, 14'h0);
        tick;
        chk("to start", up_start, 1);
        seen = 1'b0;
        for (int k = 1; k < 20; k++) begin
            tick;
            if (err === 1'b1) seen = 1'b1;
        end
        chk("to no_early_err", seen, 0);
        tick;
        chk("to err", err, 1);
        chk("to busy", busy, 0);
        chk("to ready", cmd_ready, 1);
        tick;
        chk("to err_pulse", err, 0);
        chk("to no_layer_done", n_ld - l0, 0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        s0 = n_start;
        l0 = n_ld;
        send(3'd0, 8'd2, 14'h0, 14'h0);
        tick;
        tick;
        up_done = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (up_start === 1'b1 || busy !== 1'b1) seen = 1'b1;
        end
        up_done = 1'b0;
        chk("lvl hold_p0", seen, 0);
        tick;
        chk("lvl start_p1", up_start, 1);
        chk("lvl ch_idx_p1", ch_idx, 1);
        tick;
        up_done = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (up_start === 1'b1 || layer_done === 1'b1) seen = 1'b1;
        end
        up_done = 1'b0;
        chk("lvl hold_p1", seen, 0);
        tick;
        chk("lvl layer_done", layer_done, 1);
        tick;
        chk("lvl start_count", n_start - s0, 2);
        chk("lvl done_count", n_ld - l0, 1);

        e0 = n_err;
        send(3'd0, 8'd5, 14'h0, 14'h0);
        tick;
        repeat (3) plane_pulse;
        tick;
        chk("rstmid ch_idx_before", ch_idx, 3);
        chk("rstmid busy_before", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid busy", busy, 0);
        chk("rstmid up_start", up_start, 0);
        chk("rstmid ch_idx", ch_idx, 0);
        tick;
        rst = 1'b0;
        tick;
        chk("rstmid ready", cmd_ready, 1);
        chk("rstmid no_err", n_err - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/upsample_layer_sched.md
Name: upsample_layer_sched

Overview:
- Channel-loop scheduler for the bilinear upsample engine.
- Accepts one layer command (size code, channel count, input/output base addresses) and fires the engine once per channel plane, waiting on the engine's done between planes.
- Rebases the engine's per-plane input/output addresses into flat feature-map memory, so a whole multi-channel layer runs from a single command.
- Sits between the generator's layer sequencer and the upsample engine top.

Parameters:
ADDR_W, 14, width of engine-local and memory addresses
CH_W, 8, width of channel count/index
TIMEOUT, 65535, max cycles waiting on up_done per plane before error (0 disables watchdog)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  layer command valid
cmd_ready  output  1  scheduler can accept command (high only in IDLE)
cmd_size  input  3  upsample size code, same encoding as engine size_upsample
cmd_nch  input  CH_W  number of channel planes
cmd_in_base  input  ADDR_W  base address of channel 0 input plane
cmd_out_base  input  ADDR_W  base address of channel 0 output plane
up_start  output  1  engine start, one-cycle pulse per plane
up_size  output  3  size code held to engine for whole layer
up_done  input  1  engine done (pulse or level)
up_addr_input  input  ADDR_W  engine-local input address
up_addr_output  input  ADDR_W  engine-local output address
mem_addr_in  output  ADDR_W  in_base + ch*in_stride + up_addr_input (combinational, mod 2^ADDR_W)
mem_addr_out  output  ADDR_W  out_base + ch*out_stride + up_addr_output (combinational, mod 2^ADDR_W)
ch_idx  output  CH_W  current channel plane
busy  output  1  high in every state except IDLE
layer_done  output  1  one-cycle pulse, layer finished successfully
err  output  1  one-cycle pulse: illegal command or watchdog timeout

Behaviour:
- Reset (async, any state): state IDLE; up_start, layer_done, err, busy, ch_idx, up_size = 0; latched bases, strides and channel count = 0; watchdog cleared. cmd_ready = 1 after reset.
- Strides from size code s: in_stride = 16 << (2s), out_stride = 64 << (2s). Legal s = 0..3; s >= 4 is illegal.
- Strides and bases are latched at accept time. Address sums wrap modulo 2^ADDR_W; no overflow flag.
- State machine:
  - IDLE: cmd_ready = 1. On cmd_valid at the edge:
    - s illegal -> err pulse next cycle, remain IDLE.
    - cmd_nch = 0 -> layer_done pulse next cycle, remain IDLE, engine never started.
    - otherwise -> latch all fields, ch_idx = 0, go LOAD.
  - LOAD: one cycle; up_size driven from latch. -> START.
  - START: up_start = 1 for exactly this cycle; watchdog cleared. -> WAIT.
  - WAIT:
    - first cycle with up_done = 1 -> NEXT.
    - TIMEOUT != 0 and watchdog reaches TIMEOUT -> err pulse, go IDLE; layer_done not asserted.
  - NEXT: hold until up_done = 0 (protects level-style done). Then:
    - ch_idx == nch-1 -> DONE.
    - otherwise ch_idx += 1 -> START.
  - DONE: layer_done = 1 for one cycle. -> IDLE.
- Latency: accept edge T -> up_start high in cycle T+2. Plane done seen at edge D with up_done low -> next up_start in cycle D+1 (if up_done already low) or the first cycle after up_done drops.
- up_done is ignored in IDLE, LOAD and START.
- cmd_valid is ignored while busy; no queuing.

Test Plan:
- Reset mid-WAIT with ch_idx=3 -> same cycle busy=0, up_start=0, ch_idx=0; next cycle cmd_ready=1.
- cmd s=1, nch=3, in_base=0x100, out_base=0x2000; engine done pulses -> 3 up_start pulses, ch_idx 0,1,2. With ch_idx=2, up_addr_input=5: mem_addr_in=0x100+2*64+5=0x185. With up_addr_output=7: mem_addr_out=0x2000+2*256+7=0x2207. Single layer_done after third done.
- Level-style up_done held high 4 cycles -> scheduler stays in NEXT; exactly one up_start per plane, never two starts for one done.
- cmd s=5 -> err pulse one cycle after accept, no up_start, cmd_ready stays 1. cmd nch=0, s=0 -> layer_done pulse, no up_start.
- TIMEOUT=20, up_done never asserted -> err pulse 20 cycles after up_start; busy=0; layer_done never asserted. Next command accepted normally.
- Wrap: s=3, out_base=0x3F00, ch_idx=0, up_addr_output=0x200 -> mem_addr_out=0x0100 (mod 2^14).
